// File: rtl/nts_dispatch_pkg.sv
// nts_dispatch_pkg: shared state encoding, mask constants and default buffer depth for the RX dispatch path
package nts_dispatch_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam logic [7:0] MASK_FULL = 8'hff;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DROP,
        ST_PREFETCH,
        ST_AVAILABLE
    } state_e;

endpackage

// File: rtl/nts_rx_buffer_mem.sv
// nts_rx_buffer_mem: simple dual-port 64-bit BRAM with registered read
//   i_wr_en/i_wr_addr/i_wr_data  write port (MAC side)
//   i_rd_en/i_rd_addr            read port (dispatch side), data on o_rd_data one cycle later
//   i_reset_n                    clears the read data register only
module nts_rx_buffer_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [63:0]           i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [63:0]           o_rd_data
);
    logic [63:0] mem_q [0:2**ADDR_WIDTH-1];
    logic [63:0] rd_data_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) rd_data_q <= '0;
        else if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
    end

    assign o_rd_data = rd_data_q;
endmodule

// File: rtl/nts_rx_buffer.sv
// nts_rx_buffer: single-packet MAC RX buffer offering a complete good frame to the NTS engine as a FWFT FIFO
//   i_mac_rx_*              MAC RX stream (byte-valid mask, data, good/bad end pulses)
//   o_dispatch_*/i_dispatch_* packet available flag, FWFT read port, word count-1, last-word mask, discard
//   o_dropped_frames        saturating count of bad, oversized or colliding frames
module nts_rx_buffer
    import nts_dispatch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [7:0]            i_mac_rx_data_valid,
    input  logic [63:0]           i_mac_rx_data,
    input  logic                  i_mac_rx_good_frame,
    input  logic                  i_mac_rx_bad_frame,
    output logic                  o_dispatch_packet_available,
    input  logic                  i_dispatch_packet_read_discard,
    output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
    output logic [7:0]            o_dispatch_data_valid,
    output logic                  o_dispatch_fifo_empty,
    input  logic                  i_dispatch_fifo_rd_en,
    output logic [63:0]           o_dispatch_fifo_rd_data,
    output logic [31:0]           o_dropped_frames
);
    state_e                state_q, state_d;
    // extra MSB marks that the last address has already been written
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, counter_q, counter_d, rd_addr;
    logic [7:0]            mask_q, mask_d, dv_q, dv_d;
    logic                  avail_q, avail_d, empty_q, empty_d, busy_q, busy_d;
    logic [31:0]           dropped_q;
    logic                  mac_word, frame_end, overflow, hold, drop_inc, we, re;

    assign mac_word  = |i_mac_rx_data_valid;
    assign frame_end = i_mac_rx_good_frame | i_mac_rx_bad_frame;
    // a word after a full buffer or after a short (last) word cannot be stored
    assign overflow  = mac_word && (wr_ptr_q[ADDR_WIDTH] || mask_q != MASK_FULL);
    assign hold      = state_q == ST_PREFETCH || state_q == ST_AVAILABLE;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        counter_d = counter_q;
        mask_d    = mask_q;
        dv_d      = dv_q;
        avail_d   = avail_q;
        empty_d   = empty_q;
        // frames arriving while a packet is held are tracked only to count them on their end pulse
        busy_d    = hold && !frame_end && (busy_q || mac_word);
        drop_inc  = hold && frame_end && (busy_q || mac_word);
        we        = 1'b0;
        re        = 1'b0;
        rd_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (mac_word) begin
                    we       = 1'b1;
                    wr_ptr_d = (ADDR_WIDTH+1)'(1);
                    mask_d   = i_mac_rx_data_valid;
                    if (i_mac_rx_bad_frame) begin
                        drop_inc = 1'b1;
                        wr_ptr_d = '0;
                    end else if (i_mac_rx_good_frame) begin
                        counter_d = '0;
                        dv_d      = i_mac_rx_data_valid;
                        state_d   = ST_PREFETCH;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (overflow) begin
                    drop_inc = frame_end;
                    wr_ptr_d = frame_end ? '0 : wr_ptr_q;
                    state_d  = frame_end ? ST_IDLE : ST_DROP;
                end else begin
                    if (mac_word) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
                        mask_d   = i_mac_rx_data_valid;
                    end
                    if (i_mac_rx_bad_frame) begin
                        drop_inc = 1'b1;
                        wr_ptr_d = '0;
                        state_d  = ST_IDLE;
                    end else if (i_mac_rx_good_frame) begin
                        counter_d = mac_word ? wr_ptr_q[ADDR_WIDTH-1:0] : wr_ptr_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                        dv_d      = mac_word ? i_mac_rx_data_valid : mask_q;
                        state_d   = ST_PREFETCH;
                    end
                end
            end
            ST_DROP: begin
                if (frame_end) begin
                    drop_inc = 1'b1;
                    wr_ptr_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_PREFETCH: begin
                re       = 1'b1;
                rd_ptr_d = '0;
                avail_d  = 1'b1;
                empty_d  = 1'b0;
                state_d  = ST_AVAILABLE;
            end
            ST_AVAILABLE: begin
                if (i_dispatch_packet_read_discard) begin
                    avail_d  = 1'b0;
                    empty_d  = 1'b1;
                    wr_ptr_d = '0;
                    // a frame already in flight must not be captured half-way
                    state_d  = busy_d ? ST_DROP : ST_IDLE;
                    busy_d   = 1'b0;
                end else if (i_dispatch_fifo_rd_en && !empty_q) begin
                    if (rd_ptr_q == counter_q) begin
                        empty_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                        re       = 1'b1;
                        rd_addr  = rd_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            counter_q <= '0;
            mask_q    <= '0;
            dv_q      <= '0;
            avail_q   <= 1'b0;
            empty_q   <= 1'b1;
            busy_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            counter_q <= counter_d;
            mask_q    <= mask_d;
            dv_q      <= dv_d;
            avail_q   <= avail_d;
            empty_q   <= empty_d;
            busy_q    <= busy_d;
            dropped_q <= (drop_inc && dropped_q != '1) ? dropped_q + 32'd1 : dropped_q;
        end
    end

    nts_rx_buffer_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr_en   (we),
        .i_wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .i_wr_data (i_mac_rx_data),
        .i_rd_en   (re),
        .i_rd_addr (rd_addr),
        .o_rd_data (o_dispatch_fifo_rd_data)
    );

    assign o_dispatch_packet_available = avail_q;
    assign o_dispatch_counter          = counter_q;
    assign o_dispatch_data_valid       = dv_q;
    assign o_dispatch_fifo_empty       = empty_q;
    assign o_dropped_frames            = dropped_q;
endmodule

// File: tb/tb_nts_rx_buffer.sv
// tb_nts_rx_buffer: scoreboard bench for nts_rx_buffer with a 16-word buffer
module tb_nts_rx_buffer;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    mac_valid = '0;
    logic [63:0]   mac_data = '0;
    logic          mac_good = 1'b0, mac_bad = 1'b0;
    logic          avail, discard = 1'b0, empty, rd_en = 1'b0;
    logic [AW-1:0] counter;
    logic [7:0]    dv;
    logic [63:0]   rd_data;
    logic [31:0]   dropped;

    logic [63:0] exp_q[$];
    int pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;

    nts_rx_buffer #(.ADDR_WIDTH(AW)) dut (
        .i_clk                          (clk),
        .i_reset_n                      (rst_n),
        .i_mac_rx_data_valid            (mac_valid),
        .i_mac_rx_data                  (mac_data),
        .i_mac_rx_good_frame            (mac_good),
        .i_mac_rx_bad_frame             (mac_bad),
        .o_dispatch_packet_available    (avail),
        .i_dispatch_packet_read_discard (discard),
        .o_dispatch_counter             (counter),
        .o_dispatch_data_valid          (dv),
        .o_dispatch_fifo_empty          (empty),
        .i_dispatch_fifo_rd_en          (rd_en),
        .o_dispatch_fifo_rd_data        (rd_data),
        .o_dropped_frames               (dropped)
    );

    // kind: 0 = good pulse after last word, 1 = bad pulse after last word, 2 = good with last word
    task automatic send_frame(input int n, input logic [7:0] last_mask, input int kind, input bit keep);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mac_data  = {$urandom, $urandom};
            mac_valid = (i == n - 1) ? last_mask : 8'hff;
            mac_good  = (kind == 2) && (i == n - 1);
            if (keep) exp_q.push_back(mac_data);
        end
        @(negedge clk);
        mac_valid = '0;
        mac_good  = (kind == 0);
        mac_bad   = (kind == 1);
        @(negedge clk);
        mac_good  = 1'b0;
        mac_bad   = 1'b0;
    endtask

    task automatic wait_avail(output int cyc);
        cyc = 0;
        while (!avail && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_word(output logic [63:0] d, output logic e);
        d = rd_data;
        e = empty;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_discard();
        discard = 1'b1;
        @(negedge clk);
        discard = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total_cnt += 6;
        if (avail !== 1'b0) $display("FAIL reset_avail got %b want 0", avail); else pass_cnt++;
        if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass_cnt++;
        if (counter !== '0) $display("FAIL reset_counter got %0d want 0", counter); else pass_cnt++;
        if (dv !== 8'h00) $display("FAIL reset_dv got %h want 00", dv); else pass_cnt++;
        if (rd_data !== 64'h0) $display("FAIL reset_rd_data got %h want 0", rd_data); else pass_cnt++;
        if (dropped !== 32'd0) $display("FAIL reset_dropped got %0d want 0", dropped); else pass_cnt++;
    endtask

    task automatic test_basic();
        int cyc;
        logic [63:0] d, w;
        logic e;
        send_frame(5, 8'h0f, 0, 1);
        total_cnt++;
        if (avail !== 1'b0) $display("FAIL basic_early_avail got %b want 0", avail); else pass_cnt++;
        wait_avail(cyc);
        total_cnt += 4;
        if (cyc !== 1) $display("FAIL basic_latency got %0d want 1", cyc); else pass_cnt++;
        if (counter !== AW'(4)) $display("FAIL basic_counter got %0d want 4", counter); else pass_cnt++;
        if (dv !== 8'h0f) $display("FAIL basic_dv got %h want 0f", dv); else pass_cnt++;
        if (empty !== 1'b0) $display("FAIL basic_empty got %b want 0", empty); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            read_word(d, e);
            w = exp_q.pop_front();
            total_cnt++;
            if (e !== 1'b0 || d !== w) $display("FAIL basic_word%0d got %h/e%b want %h/e0", i, d, e, w); else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL basic_empty_after got %b want 1", empty); else pass_cnt++;
        do_discard();
        total_cnt++;
        if (avail !== 1'b0) $display("FAIL basic_discard_avail got %b want 0", avail); else pass_cnt++;
    endtask

    task automatic test_bad_then_single();
        int cyc;
        logic [63:0] d, w;
        logic e;
        send_frame(3, 8'hff, 1, 0);
        @(negedge clk);
        total_cnt += 2;
        if (avail !== 1'b0) $display("FAIL bad_avail got %b want 0", avail); else pass_cnt++;
        if (dropped !== 32'd1) $display("FAIL bad_dropped got %0d want 1", dropped); else pass_cnt++;
        send_frame(1, 8'h01, 0, 1);
        wait_avail(cyc);
        total_cnt += 3;
        if (avail !== 1'b1) $display("FAIL single_avail got %b want 1", avail); else pass_cnt++;
        if (counter !== AW'(0)) $display("FAIL single_counter got %0d want 0", counter); else pass_cnt++;
        if (dv !== 8'h01) $display("FAIL single_dv got %h want 01", dv); else pass_cnt++;
        read_word(d, e);
        w = exp_q.pop_front();
        total_cnt += 2;
        if (e !== 1'b0 || d !== w) $display("FAIL single_word got %h/e%b want %h/e0", d, e, w); else pass_cnt++;
        if (empty !== 1'b1) $display("FAIL single_empty got %b want 1", empty); else pass_cnt++;
        do_discard();
    endtask

    task automatic test_oversize();
        int cyc;
        logic [63:0] d, w;
        logic e;
        send_frame(2**AW + 1, 8'hff, 0, 0);
        repeat (2) @(negedge clk);
        total_cnt += 2;
        if (avail !== 1'b0) $display("FAIL oversize_avail got %b want 0", avail); else pass_cnt++;
        if (dropped !== 32'd2) $display("FAIL oversize_dropped got %0d want 2", dropped); else pass_cnt++;
        send_frame(2, 8'h3f, 0, 1);
        wait_avail(cyc);
        total_cnt += 3;
        if (avail !== 1'b1) $display("FAIL after_oversize_avail got %b want 1", avail); else pass_cnt++;
        if (counter !== AW'(1)) $display("FAIL after_oversize_counter got %0d want 1", counter); else pass_cnt++;
        if (dv !== 8'h3f) $display("FAIL after_oversize_dv got %h want 3f", dv); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            read_word(d, e);
            w = exp_q.pop_front();
            total_cnt++;
            if (e !== 1'b0 || d !== w) $display("FAIL after_oversize_word%0d got %h want %h", i, d, w); else pass_cnt++;
        end
        do_discard();
    endtask

    task automatic test_held_drop();
        int cyc;
        logic [63:0] d, w;
        logic e;
        send_frame(3, 8'hff, 0, 1);
        wait_avail(cyc);
        send_frame(4, 8'hff, 0, 0);
        total_cnt += 3;
        if (dropped !== 32'd3) $display("FAIL held_dropped got %0d want 3", dropped); else pass_cnt++;
        if (avail !== 1'b1) $display("FAIL held_avail got %b want 1", avail); else pass_cnt++;
        if (counter !== AW'(2)) $display("FAIL held_counter got %0d want 2", counter); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            read_word(d, e);
            w = exp_q.pop_front();
            total_cnt++;
            if (e !== 1'b0 || d !== w) $display("FAIL held_word%0d got %h want %h", i, d, w); else pass_cnt++;
        end
        do_discard();
        send_frame(2, 8'h03, 2, 1);
        wait_avail(cyc);
        total_cnt += 3;
        if (avail !== 1'b1) $display("FAIL third_avail got %b want 1", avail); else pass_cnt++;
        if (counter !== AW'(1)) $display("FAIL third_counter got %0d want 1", counter); else pass_cnt++;
        if (dv !== 8'h03) $display("FAIL third_dv got %h want 03", dv); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            read_word(d, e);
            w = exp_q.pop_front();
            total_cnt++;
            if (e !== 1'b0 || d !== w) $display("FAIL third_word%0d got %h want %h", i, d, w); else pass_cnt++;
        end
        do_discard();
    endtask

    task automatic test_rd_discard();
        int cyc;
        logic [63:0] d, w, last;
        logic e;
        send_frame(3, 8'hff, 0, 1);
        wait_avail(cyc);
        read_word(d, e);
        w = exp_q.pop_front();
        total_cnt++;
        if (e !== 1'b0 || d !== w) $display("FAIL rdd_word0 got %h want %h", d, w); else pass_cnt++;
        rd_en = 1'b1;
        discard = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        discard = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        total_cnt += 2;
        if (avail !== 1'b0) $display("FAIL rdd_avail got %b want 0", avail); else pass_cnt++;
        if (empty !== 1'b1) $display("FAIL rdd_empty got %b want 1", empty); else pass_cnt++;
        send_frame(2, 8'hff, 0, 1);
        wait_avail(cyc);
        for (int i = 0; i < 2; i++) begin
            read_word(d, e);
            w = exp_q.pop_front();
            total_cnt++;
            if (e !== 1'b0 || d !== w) $display("FAIL rdd_next_word%0d got %h want %h", i, d, w); else pass_cnt++;
        end
        last = w;
        read_word(d, e);
        read_word(d, e);
        total_cnt += 2;
        if (empty !== 1'b1) $display("FAIL rd_empty_stays got %b want 1", empty); else pass_cnt++;
        if (rd_data !== last) $display("FAIL rd_empty_data got %h want %h", rd_data, last); else pass_cnt++;
        do_discard();
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [63:0] d, w;
        logic e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mac_data  = {$urandom, $urandom};
            mac_valid = 8'hff;
        end
        @(negedge clk);
        mac_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt += 4;
        if (avail !== 1'b0) $display("FAIL mid_reset_avail got %b want 0", avail); else pass_cnt++;
        if (empty !== 1'b1) $display("FAIL mid_reset_empty got %b want 1", empty); else pass_cnt++;
        if (dropped !== 32'd0) $display("FAIL mid_reset_dropped got %0d want 0", dropped); else pass_cnt++;
        if (rd_data !== 64'h0) $display("FAIL mid_reset_rd_data got %h want 0", rd_data); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (dropped !== 32'd0) $display("FAIL mid_reset_not_counted got %0d want 0", dropped); else pass_cnt++;
        send_frame(2, 8'h7f, 0, 1);
        wait_avail(cyc);
        total_cnt += 2;
        if (counter !== AW'(1)) $display("FAIL post_reset_counter got %0d want 1", counter); else pass_cnt++;
        if (dv !== 8'h7f) $display("FAIL post_reset_dv got %h want 7f", dv); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            read_word(d, e);
            w = exp_q.pop_front();
            total_cnt++;
            if (e !== 1'b0 || d !== w) $display("FAIL post_reset_word%0d got %h want %h", i, d, w); else pass_cnt++;
        end
        do_discard();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_then_single();
        test_oversize();
        test_held_drop();
        test_rd_discard();
        test_reset_mid();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
